mic_adc_capture: RTL and testbench

- Upstream feeder for the signal-delay stage. Periodically reads one sample from an external serial (SPI-style, read-only) microphone ADC.
- Reduces each sample to D_WIDTH bits and presents it on sample, together with a one-cycle sample_valid strobe.
- sample drives mic_signal of the delay stage. sample_valid drives its en/writeEn, so the delay address advances once per audio sample.

---
 rtl/mic_adc_capture.sv | 173 +++++++++++++++++
 tb/tb_mic_adc_capture.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mic_adc_capture.sv
`default_nettype none
// ============================================================================
// Module      : mic_adc_capture
// Description : Periodic serial microphone ADC reader feeding the delay stage.
//               Optional DC-blocking output stage when MIC_DC_BLOCK_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module mic_adc_capture #(
    parameter int D_WIDTH       = 8,
    parameter int ADC_BITS      = 12,
    parameter int SCLK_DIV      = 4,
    parameter int SAMPLE_PERIOD = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               adc_sdo,
    output logic               adc_cs_n,
    output logic               adc_sclk,
    output logic [D_WIDTH-1:0] sample,
    output logic               sample_valid,
    output logic               busy,
    output logic               overrun
);

    localparam int c_TIMER_W = $clog2(SAMPLE_PERIOD);
    localparam int c_DIV_W   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int c_EDGE_W  = $clog2(2 * ADC_BITS);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CS_SETUP = 2'd1,
        S_SHIFT    = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [c_TIMER_W-1:0]  r_timer;
    logic [c_DIV_W-1:0]    r_div_cnt;
    logic [c_EDGE_W-1:0]   r_edge_cnt;
    logic [ADC_BITS-1:0]   r_shift;
    logic                  r_cs_n;
    logic                  r_sclk;
    logic [D_WIDTH-1:0]    r_sample;
    logic                  r_valid;
    logic                  r_overrun;

    logic                  w_start;
    logic                  w_div_last;
    logic                  w_edge_last;
    logic [D_WIDTH-1:0]    w_trunc;
    logic [D_WIDTH-1:0]    w_sample_next;

    assign w_start     = en && (r_timer == '0);
    assign w_div_last  = (r_div_cnt == c_DIV_W'(SCLK_DIV - 1));
    assign w_edge_last = (r_edge_cnt == c_EDGE_W'(2 * ADC_BITS - 1));
    assign w_trunc     = r_shift[ADC_BITS-1 -: D_WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     if (w_start) w_state_next = S_CS_SETUP;
            S_CS_SETUP: if (w_div_last) w_state_next = S_SHIFT;
            S_SHIFT:    if (w_div_last && w_edge_last) w_state_next = S_DONE;
            S_DONE:     w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer    <= '0;
            r_div_cnt  <= '0;
            r_edge_cnt <= '0;
            r_shift    <= '0;
            r_cs_n     <= 1'b1;
            r_sclk     <= 1'b0;
            r_sample   <= '0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (en) begin
                r_timer <= (r_timer == c_TIMER_W'(SAMPLE_PERIOD - 1)) ? '0
                         : r_timer + c_TIMER_W'(1);
            end

            // A start that lands on an active conversion is dropped.
            if (w_start && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end

            if ((r_state == S_CS_SETUP) || (r_state == S_SHIFT)) begin
                r_div_cnt <= w_div_last ? '0 : r_div_cnt + c_DIV_W'(1);
            end else begin
                r_div_cnt <= '0;
            end

            if (r_state == S_SHIFT) begin
                if (w_div_last) begin
                    r_edge_cnt <= r_edge_cnt + c_EDGE_W'(1);
                    r_sclk     <= ~r_sclk;
                    if (!r_sclk) begin
                        r_shift <= {r_shift[ADC_BITS-2:0], adc_sdo};
                    end
                end
            end else begin
                r_edge_cnt <= '0;
            end

            r_cs_n  <= !((w_state_next == S_CS_SETUP) || (w_state_next == S_SHIFT));
            r_valid <= (r_state == S_DONE);
            if (r_state == S_DONE) begin
                r_sample <= w_sample_next;
            end
        end
    end

`ifdef MIC_DC_BLOCK_EN
    localparam int c_DC_W = D_WIDTH + 4;
    localparam logic [c_DC_W-1:0]         c_DC_RST = c_DC_W'((2 ** (D_WIDTH - 1)) * 16);
    localparam logic signed [D_WIDTH+1:0] c_MID    = (D_WIDTH + 2)'(2 ** (D_WIDTH - 1));
    localparam logic signed [D_WIDTH+1:0] c_MAX    = (D_WIDTH + 2)'((2 ** D_WIDTH) - 1);

    logic [c_DC_W-1:0]         r_dc;
    logic signed [D_WIDTH+1:0] w_dev;
    logic signed [c_DC_W:0]    w_err;
    logic [c_DC_W-1:0]         w_dc_next;

    // Output is re-centred on mid-scale using the estimate before this update.
    always_comb begin
        w_dev     = $signed({2'b00, w_trunc}) - $signed({2'b00, r_dc[c_DC_W-1:4]}) + c_MID;
        w_err     = $signed({1'b0, w_trunc, 4'b0000}) - $signed({1'b0, r_dc});
        w_dc_next = r_dc + c_DC_W'(w_err >>> 4);
        if (w_dev[D_WIDTH+1]) begin
            w_sample_next = '0;
        end else if (w_dev > c_MAX) begin
            w_sample_next = '1;
        end else begin
            w_sample_next = w_dev[D_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dc <= c_DC_RST;
        end else if (r_state == S_DONE) begin
            r_dc <= w_dc_next;
        end
    end
`else
    always_comb begin
        w_sample_next = w_trunc;
    end
`endif

    assign adc_cs_n     = r_cs_n;
    assign adc_sclk     = r_sclk;
    assign sample       = r_sample;
    assign sample_valid = r_valid;
    assign busy         = (r_state != S_IDLE);
    assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_mic_adc_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_mic_adc_capture
// Description : Directed scoreboard bench for mic_adc_capture (default and
//               short-period instances, DC-block checks with MIC_DC_BLOCK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mic_adc_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b0, en_a = 1'b0, sdo_a = 1'b0;
    logic       rst_b = 1'b0, en_b = 1'b0, sdo_b = 1'b0;
    logic       cs_n_a, sclk_a, valid_a, busy_a, ovr_a;
    logic       cs_n_b, sclk_b, valid_b, busy_b, ovr_b;
    logic [7:0] sample_a, sample_b;

    mic_adc_capture u_dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .adc_sdo(sdo_a),
        .adc_cs_n(cs_n_a), .adc_sclk(sclk_a), .sample(sample_a),
        .sample_valid(valid_a), .busy(busy_a), .overrun(ovr_a)
    );

    mic_adc_capture #(.SAMPLE_PERIOD(64)) u_dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .adc_sdo(sdo_b),
        .adc_cs_n(cs_n_b), .adc_sclk(sclk_b), .sample(sample_b),
        .sample_valid(valid_b), .busy(busy_b), .overrun(ovr_b)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int nv_a  = 0;
    int nv_b  = 0;
    int dc_a  = 2048;
    int dc_b  = 2048;
    logic [7:0]  exp_a[$];
    logic [7:0]  exp_b[$];
    logic [11:0] word_a = 12'h000;
    logic [11:0] word_b = 12'h000;
    int idx_a = 0;
    int idx_b = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ADC models: MSB presented at CS fall, next bit after each SCLK fall.
    always @(negedge cs_n_a) begin idx_a = 11; sdo_a = word_a[idx_a]; end
    always @(negedge sclk_a) if (!cs_n_a && idx_a > 0) begin idx_a--; sdo_a = word_a[idx_a]; end
    always @(negedge cs_n_b) begin idx_b = 11; sdo_b = word_b[idx_b]; end
    always @(negedge sclk_b) if (!cs_n_b && idx_b > 0) begin idx_b--; sdo_b = word_b[idx_b]; end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic dc_model(input logic [11:0] w, inout int dc, output logic [7:0] y);
        int t;
        int d;
        t = int'(w[11:4]);
`ifdef MIC_DC_BLOCK_EN
        d  = t - (dc / 16) + 128;
        y  = (d < 0) ? 8'd0 : ((d > 255) ? 8'd255 : d[7:0]);
        dc = dc + ((t * 16 - dc) >>> 4);
`else
        d  = t;
        y  = d[7:0];
`endif
    endtask

    task automatic push_a(input logic [11:0] w);
        logic [7:0] y;
        dc_model(w, dc_a, y);
        exp_a.push_back(y);
    endtask

    task automatic push_b(input logic [11:0] w);
        logic [7:0] y;
        dc_model(w, dc_b, y);
        exp_b.push_back(y);
    endtask

    task automatic see_valid_a();
        if (valid_a) begin
            nv_a++;
            if (exp_a.size() > 0) check("sample_a", 32'(sample_a), 32'(exp_a.pop_front()));
            else check("spurious_valid_a", 32'(valid_a), 32'd0);
        end
    endtask

    task automatic see_valid_b();
        if (valid_b) begin
            nv_b++;
            if (exp_b.size() > 0) check("sample_b", 32'(sample_b), 32'(exp_b.pop_front()));
            else check("spurious_valid_b", 32'(valid_b), 32'd0);
        end
    endtask

    task automatic wait_cs_low_a(output int n);
        n = 0;
        while (cs_n_a && n < 400) begin
            @(negedge clk);
            see_valid_a();
            n++;
        end
    endtask

`ifdef MIC_DC_BLOCK_EN
    task automatic conv_a(input logic [11:0] w, output logic [7:0] y);
        int n;
        word_a = w;
        push_a(w);
        nv_a = 0;
        n = 0;
        while (nv_a == 0 && n < 400) begin
            @(negedge clk);
            see_valid_a();
            n++;
        end
        check("dc_conv_done", 32'(nv_a), 32'd1);
        y = sample_a;
    endtask
`endif

    initial begin
        int busyc, csc, hic, rises, first_rise, vat, n, first_ovr;
        int tv[3];
        logic prev;
`ifdef MIC_DC_BLOCK_EN
        logic [7:0] y1, y2, y3, y4, y5;
`endif
        busyc = 0; csc = 0; hic = 0; rises = 0; first_rise = -1; vat = -1;
        first_ovr = -1; tv[0] = 0; tv[1] = 0; tv[2] = 0;
        word_b = 12'h9F3;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(cs_n_a), 32'd1);
        check("rst_sclk", 32'(sclk_a), 32'd0);
        check("rst_sample", 32'(sample_a), 32'd0);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_overrun", 32'(ovr_a), 32'd0);

        // First conversion: 0xA5C, timing of CS/SCLK/busy/valid
        rst_a = 1'b1;
        @(negedge clk);
        word_a = 12'hA5C;
        push_a(12'hA5C);
        en_a = 1'b1;
        @(negedge clk);
        check("cs_low_at_start", 32'(cs_n_a), 32'd0);
        prev = 1'b0;
        nv_a = 0;
        for (int i = 0; i < 120; i++) begin
            if (busy_a) busyc++;
            if (!cs_n_a) csc++;
            if (sclk_a) hic++;
            if (sclk_a && !prev) begin
                rises++;
                if (first_rise < 0) first_rise = i;
            end
            prev = sclk_a;
            if (valid_a) vat = i;
            see_valid_a();
            @(negedge clk);
        end
        check("busy_cycles", 32'(busyc), 32'd101);
        check("cs_low_cycles", 32'(csc), 32'd100);
        check("sclk_rises", 32'(rises), 32'd12);
        check("sclk_high_cycles", 32'(hic), 32'd48);
        check("first_rise", 32'(first_rise), 32'd8);
        check("valid_latency", 32'(vat), 32'd101);
        check("valid_count1", 32'(nv_a), 32'd1);

        // Three periods of all-ones data
        word_a = 12'hFFF;
        repeat (3) push_a(12'hFFF);
        nv_a = 0;
        for (int i = 0; i < 800; i++) begin
            if (valid_a && nv_a < 3) tv[nv_a] = cyc;
            see_valid_a();
            @(negedge clk);
        end
        check("valid_count3", 32'(nv_a), 32'd3);
        check("period_1", 32'(tv[1] - tv[0]), 32'd256);
        check("period_2", 32'(tv[2] - tv[1]), 32'd256);
        check("overrun_a", 32'(ovr_a), 32'd0);

        // en dropped 20 clocks into a conversion
        word_a = 12'h3C7;
        push_a(12'h3C7);
        wait_cs_low_a(n);
        check("start3_seen", 32'(cs_n_a), 32'd0);
        nv_a = 0;
        repeat (20) begin
            @(negedge clk);
            see_valid_a();
        end
        en_a = 1'b0;
        busyc = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            see_valid_a();
        end
        check("valid_after_en_drop", 32'(nv_a), 32'd1);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy_a) busyc++;
        end
        check("no_start_while_off", 32'(busyc), 32'd0);
        word_a = 12'h5A0;
        push_a(12'h5A0);
        en_a = 1'b1;
        wait_cs_low_a(n);
        check("resume_delay", 32'(n), 32'd236);
        nv_a = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            see_valid_a();
        end
        check("valid_after_resume", 32'(nv_a), 32'd1);

        // Reset in the middle of SHIFT, after 5 bits
        word_a = 12'hFFF;
        wait_cs_low_a(n);
        rises = 0;
        prev = sclk_a;
        n = 0;
        while (rises < 5 && n < 100) begin
            @(negedge clk);
            if (sclk_a && !prev) rises++;
            prev = sclk_a;
            n++;
        end
        rst_a = 1'b0;
        en_a = 1'b0;
        dc_a = 2048;
        #1;
        check("midrst_cs_n", 32'(cs_n_a), 32'd1);
        check("midrst_sclk", 32'(sclk_a), 32'd0);
        check("midrst_busy", 32'(busy_a), 32'd0);
        check("midrst_sample", 32'(sample_a), 32'd0);
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        nv_a = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            see_valid_a();
        end
        check("midrst_no_valid", 32'(nv_a), 32'd0);
        check("midrst_sample_hold", 32'(sample_a), 32'd0);

        // Short period instance: overrun on the second start
        @(negedge clk);
        rst_b = 1'b1;
        repeat (3) push_b(12'h9F3);
        en_b = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 400; i++) begin
            if (ovr_b && first_ovr < 0) first_ovr = i;
            see_valid_b();
            @(negedge clk);
        end
        check("overrun_first", 32'(first_ovr), 32'd64);
        check("overrun_sticky", 32'(ovr_b), 32'd1);
        check("valid_count_b", 32'(nv_b), 32'd3);

`ifdef MIC_DC_BLOCK_EN
        // DC block: flat mid-scale then a step
        en_a = 1'b1;
        conv_a(12'h800, y1);
        conv_a(12'h800, y2);
        conv_a(12'hC00, y3);
        conv_a(12'hC00, y4);
        conv_a(12'hC00, y5);
        check("dc_flat1", 32'(y1), 32'h80);
        check("dc_flat2", 32'(y2), 32'h80);
        check("dc_step", 32'(y3), 32'hC0);
        check("dc_decay1", 32'(y4 < y3), 32'd1);
        check("dc_decay2", 32'(y5 < y4), 32'd1);
        check("dc_above_mid", 32'(y5 > 8'h80), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
